// File: rtl/sys_clken_gen.sv
// Multi-channel clock-enable generator: divided and phase-offset strobes
// derived from one reference clock, with a relock window after each change.
module sys_clken_gen #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 8,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd4, 8'd4},
  parameter logic [NUM_CH*DIV_W-1:0] PHASE_INIT = {8'd1, 8'd0}
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] out_clk,
  output logic              locked
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [4:0] NCH = 5'(NUM_CH);
  localparam logic [0:0] ST_LOCKING = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]     state;
  logic [LCW-1:0] lock_cnt;
  logic           take;
  logic           chan_ok;
  logic           wr;

  assign take = cfg_valid & cfg_ready;
  assign chan_ok = {1'b0, cfg_chan} < NCH;
  assign wr = take & chan_ok;
  assign locked = state == ST_LOCKED;
  assign cfg_ready = locked;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state <= ST_LOCKING;
      lock_cnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= take & ~chan_ok;
      if (wr) begin
        state <= ST_LOCKING;
        lock_cnt <= '0;
      end else if (state == ST_LOCKING) begin
        if (lock_cnt == LOCK_LAST) state <= ST_LOCKED;
        else lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [3:0] IDX = 4'(i);
    localparam logic [DIV_W-1:0] D_INI = DIV_INIT[i*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] P_INI = PHASE_INIT[i*DIV_W +: DIV_W];

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] p_eff;
    logic [DIV_W:0]   d_x;
    logic [DIV_W:0]   p_x;
    logic [DIV_W:0]   c_x;
    logic [DIV_W:0]   q;
    logic [DIV_W:0]   half;
    logic             sel;

    assign sel = wr & (cfg_chan == IDX);
    assign d_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    assign p_eff = (phase_q > d_eff - 1'b1) ? d_eff - 1'b1 : phase_q;
    assign d_x = {1'b0, d_eff};
    assign p_x = {1'b0, p_eff};
    assign c_x = {1'b0, cnt_q};

    // cnt and phase are both below D, so one conditional add is the modulo
    assign q = (c_x >= p_x) ? c_x - p_x : c_x + d_x - p_x;
    assign half = (d_x + 1'b1) >> 1;

    always_ff @(posedge refclk) begin
      if (!rst_n) begin
        div_q <= D_INI;
        phase_q <= P_INI;
        cnt_q <= '0;
      end else begin
        if (sel) begin
          div_q <= cfg_div;
          phase_q <= cfg_phase;
        end
        if (wr) cnt_q <= '0;
        else if (cnt_q == d_eff - 1'b1) cnt_q <= '0;
        else cnt_q <= cnt_q + 1'b1;
      end
    end

    assign clk_en[i] = locked & (q == '0);
    assign out_clk[i] = locked & (q < half);
  end

endmodule

// File: tb/tb_sys_clken_gen.sv
// Bench for sys_clken_gen: vector table, directed corners, and a random
// config stream checked against a cycle-count reference model.
module tb_sys_clken_gen;

  localparam int NUM_CH = 2;
  localparam int DIV_W = 8;
  localparam int LOCK_CYCLES = 16;

  logic              refclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [3:0]        cfg_chan = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [DIV_W-1:0]  cfg_phase = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] out_clk;
  logic              locked;

  sys_clken_gen #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .LOCK_CYCLES(LOCK_CYCLES),
    .DIV_INIT({8'd4, 8'd4}),
    .PHASE_INIT({8'd1, 8'd0})
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_div(cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_err(cfg_err),
    .clk_en(clk_en),
    .out_clk(out_clk),
    .locked(locked)
  );

  always #5 refclk = ~refclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: k counts cycles since the last realignment (reset or good accept)
  int k = 0;
  int md[NUM_CH];
  int mp[NUM_CH];
  bit merr = 0;

  typedef struct {
    int         cyc;
    logic       lk;
    logic [1:0] en;
    logic [1:0] oc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (k=%0d)", nm, act, exp, k);
    end
  endtask

  function automatic int eff_d(int ch);
    return (md[ch] == 0) ? 1 : md[ch];
  endfunction

  function automatic int eff_p(int ch);
    int d = eff_d(ch);
    return (mp[ch] > d - 1) ? d - 1 : mp[ch];
  endfunction

  function automatic int qv(int ch);
    int d = eff_d(ch);
    return ((k % d) - eff_p(ch) + d) % d;
  endfunction

  task automatic model_reset();
    md[0] = 4; mp[0] = 0;
    md[1] = 4; mp[1] = 1;
    k = 0;
    merr = 0;
  endtask

  task automatic check_model();
    logic [NUM_CH-1:0] ee;
    logic [NUM_CH-1:0] eo;
    bit lk;
    lk = k >= LOCK_CYCLES;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ee[ch] = lk && qv(ch) == 0;
      eo[ch] = lk && qv(ch) < (eff_d(ch) + 1) / 2;
    end
    chk("m_locked", int'(locked), int'(lk));
    chk("m_ready", int'(cfg_ready), int'(lk));
    chk("m_err", int'(cfg_err), int'(merr));
    chk("m_clk_en", int'(clk_en), int'(ee));
    chk("m_out_clk", int'(out_clk), int'(eo));
  endtask

  task automatic step();
    bit acc;
    acc = cfg_valid && (k >= LOCK_CYCLES);
    if (!rst_n) begin
      model_reset();
    end else if (acc && cfg_chan < NUM_CH) begin
      md[cfg_chan] = int'(cfg_div);
      mp[cfg_chan] = int'(cfg_phase);
      k = 0;
      merr = 0;
    end else begin
      merr = acc;
      k++;
    end
    @(posedge refclk);
    #1;
    check_model();
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 1000 && k < target; n++) step();
  endtask

  task automatic do_cfg(input int ch, input int dv, input int ph,
                        output int waits);
    bit acc;
    waits = 0;
    acc = 0;
    cfg_chan = 4'(ch);
    cfg_div = 8'(dv);
    cfg_phase = 8'(ph);
    cfg_valid = 1'b1;
    for (int n = 0; n < 400 && !acc; n++) begin
      acc = k >= LOCK_CYCLES;
      if (!acc) waits++;
      step();
    end
    cfg_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cfg_timeout: got no accept want accept");
    end
  endtask

  task automatic apply_table();
    for (int j = 0; j < 9; j++) begin
      run_to(tbl[j].cyc);
      chk($sformatf("tbl%0d_locked", j), int'(locked), int'(tbl[j].lk));
      chk($sformatf("tbl%0d_ready", j), int'(cfg_ready), int'(tbl[j].lk));
      chk($sformatf("tbl%0d_en", j), int'(clk_en), int'(tbl[j].en));
      chk($sformatf("tbl%0d_oclk", j), int'(out_clk), int'(tbl[j].oc));
    end
  endtask

  initial begin
    int w;
    int k0;
    tbl[0] = '{0, 1'b0, 2'b00, 2'b00};
    tbl[1] = '{15, 1'b0, 2'b00, 2'b00};
    tbl[2] = '{16, 1'b1, 2'b01, 2'b01};
    tbl[3] = '{17, 1'b1, 2'b10, 2'b11};
    tbl[4] = '{18, 1'b1, 2'b00, 2'b10};
    tbl[5] = '{19, 1'b1, 2'b00, 2'b00};
    tbl[6] = '{20, 1'b1, 2'b01, 2'b01};
    tbl[7] = '{21, 1'b1, 2'b10, 2'b11};
    tbl[8] = '{24, 1'b1, 2'b01, 2'b01};

    model_reset();
    repeat (3) step();
    chk("rst_err", int'(cfg_err), 0);
    rst_n = 1'b1;
    apply_table();

    // Reconfigure channel 0 while locked
    do_cfg(0, 3, 2, w);
    chk("recfg_wait", w, 0);
    chk("recfg_unlock", int'(locked), 0);
    run_to(15);
    chk("recfg_lo15", int'(locked), 0);
    run_to(16);
    chk("recfg_hi16", int'(locked), 1);
    chk("recfg_en16", int'(clk_en), 0);
    run_to(17);
    chk("recfg_en17", int'(clk_en), 3);
    run_to(20);
    chk("recfg_en20", int'(clk_en), 1);
    run_to(21);
    chk("recfg_en21", int'(clk_en), 2);

    // Nonexistent channel, single then back-to-back
    cfg_chan = 4'd5;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("bad_err", int'(cfg_err), 1);
    chk("bad_locked", int'(locked), 1);
    step();
    chk("bad_err_clr", int'(cfg_err), 0);
    cfg_chan = 4'd9;
    cfg_valid = 1'b1;
    step();
    chk("b2b_err0", int'(cfg_err), 1);
    step();
    chk("b2b_err1", int'(cfg_err), 1);
    cfg_valid = 1'b0;
    step();
    chk("b2b_clr", int'(cfg_err), 0);

    // Request held through a whole LOCKING window
    do_cfg(1, 5, 3, w);
    chk("hold_first", w, 0);
    do_cfg(1, 6, 1, w);
    chk("hold_wait", w, LOCK_CYCLES);
    chk("hold_unlock", int'(locked), 0);
    run_to(30);

    // div=0 and div=1 degenerate to every cycle
    do_cfg(0, 0, 0, w);
    run_to(16);
    for (int n = 0; n < 6; n++) begin
      chk("d0_en", int'(clk_en[0]), 1);
      chk("d0_oclk", int'(out_clk[0]), 1);
      step();
    end
    do_cfg(0, 1, 5, w);
    run_to(16);
    for (int n = 0; n < 6; n++) begin
      chk("d1_en", int'(clk_en[0]), 1);
      chk("d1_oclk", int'(out_clk[0]), 1);
      step();
    end

    // Phase beyond D-1 clamps
    do_cfg(0, 3, 7, w);
    run_to(16);
    for (int n = 0; n < 6; n++) begin
      chk("d3p7_en", int'(clk_en[0]), int'(k % 3 == 2));
      step();
    end

    // Largest divide
    do_cfg(0, 255, 254, w);
    run_to(16);
    for (int n = 0; n < 400 && !clk_en[0]; n++) step();
    chk("d255_first", k, 254);
    k0 = k;
    step();
    for (int n = 0; n < 400 && !clk_en[0]; n++) step();
    chk("d255_gap", k - k0, 255);

    // Reset during relock discards the written divide
    do_cfg(0, 3, 0, w);
    run_to(5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    apply_table();

    // Reset wins over a simultaneous accept
    cfg_chan = 4'd0;
    cfg_div = 8'd9;
    cfg_phase = 8'd0;
    cfg_valid = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cfg_valid = 1'b0;
    apply_table();

    // Random config stream
    for (int it = 0; it < 150; it++) begin
      int r;
      int ch;
      int dv;
      int ph;
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        repeat ($urandom_range(1, 20)) step();
      end else begin
        ch = int'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) ch = 15;
        case ($urandom_range(0, 3))
          0: dv = int'($urandom_range(0, 2));
          1, 2: dv = int'($urandom_range(2, 12));
          default: dv = int'($urandom_range(0, 255));
        endcase
        ph = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 12))
                                         : int'($urandom_range(0, 255));
        do_cfg(ch, dv, ph, w);
        repeat ($urandom_range(0, 40)) step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
